// File: rtl/playback_serializer_if.sv
// Controller command/status and clip BRAM read-port signals of the playback serializer.
// The serializer takes the slave side; the controller/BRAM owner takes the master side.
interface playback_serializer_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 17
) ();
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] startAddress;
    logic [ADDR_W-1:0] wordCount;
    logic [WORD_W-1:0] memData;
    logic              memEn;
    logic [ADDR_W-1:0] memAddr;
    logic              audioOut;
    logic              busy;
    logic              done;

    modport slave (
        input  start, abort, startAddress, wordCount, memData,
        output memEn, memAddr, audioOut, busy, done
    );

    modport master (
        output start, abort, startAddress, wordCount, memData,
        input  memEn, memAddr, audioOut, busy, done
    );
endinterface

// File: rtl/playback_serializer.sv
// Streams a run of packed PDM words from a clip BRAM out MSB-first, one bit per CLK_DIV clocks,
// with a one-word prefetch buffer so word boundaries carry no gap.
module playback_serializer #(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 17,
    parameter int CLK_DIV = 50
) (
    input logic                   clock,
    input logic                   reset,
    playback_serializer_if.slave  bus
);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [ADDR_W-1:0] remaining, remaining_nx;
    logic [ADDR_W-1:0] mem_addr, mem_addr_nx;
    logic [WORD_W-1:0] shift_reg, shift_nx;
    logic [WORD_W-1:0] next_buf, next_buf_nx;
    logic [BIT_W-1:0]  bit_idx, bit_idx_nx;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
    logic              mem_en, mem_en_nx;
    logic              audio_out, audio_nx;
    logic              done_r, done_nx;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_nx     = state;
        addr_nx      = addr;
        remaining_nx = remaining;
        mem_addr_nx  = mem_addr;
        shift_nx     = shift_reg;
        next_buf_nx  = next_buf;
        bit_idx_nx   = bit_idx;
        div_cnt_nx   = div_cnt;
        mem_en_nx    = 1'b0;
        done_nx      = 1'b0;
        audio_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.wordCount != '0) begin
                        addr_nx      = bus.startAddress;
                        remaining_nx = bus.wordCount;
                        mem_en_nx    = 1'b1;
                        mem_addr_nx  = bus.startAddress;
                        state_nx     = FETCH;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            FETCH: state_nx = WAIT;
            WAIT: begin
                shift_nx   = bus.memData;
                bit_idx_nx = '0;
                div_cnt_nx = '0;
                state_nx   = PLAY;
                // The prefetch read is issued in the first PLAY cycle of every word.
                if (remaining > ADDR_W'(1)) begin
                    mem_en_nx   = 1'b1;
                    mem_addr_nx = addr + ADDR_W'(1);
                end
            end
            PLAY: begin
                if (bit_idx == '0 && div_cnt == DIV_W'(1) && remaining > ADDR_W'(1))
                    next_buf_nx = bus.memData;
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_nx = '0;
                    if (bit_idx == BIT_W'(WORD_W - 1)) begin
                        if (remaining > ADDR_W'(1)) begin
                            shift_nx     = next_buf;
                            addr_nx      = addr + ADDR_W'(1);
                            remaining_nx = remaining - ADDR_W'(1);
                            bit_idx_nx   = '0;
                            if (remaining > ADDR_W'(2)) begin
                                mem_en_nx   = 1'b1;
                                mem_addr_nx = addr + ADDR_W'(2);
                            end
                        end else begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        shift_nx   = shift_reg << 1;
                        bit_idx_nx = bit_idx + BIT_W'(1);
                    end
                end else begin
                    div_cnt_nx = div_cnt + DIV_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE && bus.abort) begin
            state_nx  = IDLE;
            mem_en_nx = 1'b0;
            done_nx   = 1'b0;
        end

        // Registering the next MSB keeps audioOut glitch-free and aligned with the shift register.
        if (state_nx == PLAY) audio_nx = shift_nx[WORD_W-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            shift_reg <= '0;
            next_buf  <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            mem_en    <= 1'b0;
            audio_out <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= remaining_nx;
            mem_addr  <= mem_addr_nx;
            shift_reg <= shift_nx;
            next_buf  <= next_buf_nx;
            bit_idx   <= bit_idx_nx;
            div_cnt   <= div_cnt_nx;
            mem_en    <= mem_en_nx;
            audio_out <= audio_nx;
            done_r    <= done_nx;
        end
    end

    assign bus.memEn    = mem_en;
    assign bus.memAddr  = mem_addr;
    assign bus.audioOut = audio_out;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
endmodule
